handshake_tx: RTL and testbench

//  Source (transmitter) side of a 4-phase req/ack handshake carrying a WIDTH-bit word out of the

---
 rtl/handshake_pkg.sv | 7 +
 rtl/ack_sync.sv | 14 +
 rtl/handshake_tx.sv | 96 +++++++++
 tb/tb_handshake_tx.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// handshake_pkg: shared handshake state encoding and counter sizing helper
package handshake_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, WAIT_HI, WAIT_LO, RECOVER} hs_state_t;
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1) < 1 ? 1 : $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/ack_sync.sv
// ack_sync: STAGES-deep synchronizer bringing the receiver ack into the Clk domain
// Ports: Clk, Reset (sync, active-low, clears chain), ack_async in, ack_s = last stage out.
module ack_sync #(
  parameter int STAGES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic ack_async,
  output logic ack_s
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge Clk) sync_q <= !Reset ? '0 : {sync_q[STAGES-2:0], ack_async};
  assign ack_s = sync_q[STAGES-1];
endmodule

// File: rtl/handshake_tx.sv
// handshake_tx: source side of a 4-phase req/ack handshake with ack sync and per-phase timeout
// Ports: Clk, Reset (sync, active-low); send_valid/send_data/send_ready requester interface;
//        ack_async from receiver; req_out/data_out registered to receiver; done/timeout pulses.
module handshake_tx
  import handshake_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             send_valid,
  input  logic [WIDTH-1:0] send_data,
  output logic             send_ready,
  input  logic             ack_async,
  output logic             req_out,
  output logic [WIDTH-1:0] data_out,
  output logic             done,
  output logic             timeout
);
  localparam int CW = cnt_width(TIMEOUT);
  hs_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic req_q, req_d, done_q, done_d, to_q, to_d;
  logic ack_s, accept, waiting, expired;
  ack_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .Clk      (Clk),
    .Reset    (Reset),
    .ack_async(ack_async),
    .ack_s    (ack_s)
  );
  // never start a new word while the receiver is still showing ack from the last one
  assign send_ready = state_q == IDLE && !ack_s;
  assign accept     = send_valid && send_ready;
  assign waiting    = state_q == WAIT_HI || state_q == WAIT_LO;
  assign expired    = TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        data_d  = send_data;
        state_d = SETUP;
      end
      SETUP: begin
        req_d   = 1'b1;
        state_d = WAIT_HI;
      end
      // an ack arriving on the expiry cycle still completes the phase
      WAIT_HI: if (ack_s) begin
        req_d   = 1'b0;
        state_d = WAIT_LO;
      end else if (expired) begin
        req_d   = 1'b0;
        to_d    = 1'b1;
        state_d = RECOVER;
      end
      WAIT_LO: if (!ack_s) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else if (expired) begin
        to_d    = 1'b1;
        state_d = RECOVER;
      end
      RECOVER: if (!ack_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = state_d != state_q ? '0 : waiting && cnt_q != '1 ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
      to_q    <= to_d;
    end
  end
  assign req_out  = req_q;
  assign data_out = data_q;
  assign done     = done_q;
  assign timeout  = to_q;
endmodule

// File: tb/tb_handshake_tx.sv
// tb_handshake_tx: scoreboard bench for handshake_tx with an auto-responding receiver model
module tb_handshake_tx;
  logic Clk = 1'b0, Reset = 1'b0, send_valid = 1'b0, ack_async = 1'b1, rx_en = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic [7:0] data_out;
  logic send_ready, req_out, done, timeout;
  int checks = 0, errors = 0;
  logic [7:0] sb[$];

  handshake_tx #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT(16)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .send_valid(send_valid),
    .send_data (send_data),
    .send_ready(send_ready),
    .ack_async (ack_async),
    .req_out   (req_out),
    .data_out  (data_out),
    .done      (done),
    .timeout   (timeout)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // receiver: follows req_out with ack_async three cycles after each req edge
  initial begin
    int dly = 0;
    forever begin
      tick();
      if (!rx_en) dly = 0;
      else if (req_out != ack_async) begin
        if (dly == 3) begin
          ack_async = req_out;
          dly = 0;
        end else dly++;
      end
    end
  end

  task automatic send(input logic [7:0] d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (send_ready) ok = 1'b1;
      else tick();
    end
    if (ok) begin
      send_valid = 1'b1;
      send_data = d;
      sb.push_back(d);
      tick();
      send_valid = 1'b0;
      send_data = ~d;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({req_out, done, timeout} !== 3'b000 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL rst_state: req=%b done=%b to=%b data=%h, want 0 0 0 00", req_out, done, timeout, data_out);
    end
    Reset = 1'b1;
    tick();
    tick();
    send_valid = 1'b1;
    send_data = 8'hEE;
    for (int t = 0; t < 4; t++) begin
      checks++;
      if (send_ready !== 1'b0) begin
        errors++;
        $display("FAIL rst_ack_block[%0d]: send_ready=%b, want 0", t, send_ready);
      end
      if (t == 2) ack_async = 1'b0;
      tick();
    end
    checks++;
    if (send_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready_after_ack: send_ready=%b, want 1", send_ready);
    end
    send_valid = 1'b0;
    tick();
    checks++;
    if (req_out !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL rst_no_accept: req=%b data=%h, want 0 00", req_out, data_out);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int n_done = 0, t_done = -1;
    logic [7:0] exp, got;
    rx_en = 1'b1;
    send(8'hA5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_accept: send_ready stayed %b, want 1", send_ready);
      return;
    end
    exp = sb[0];
    checks++;
    if (req_out !== 1'b0 || data_out !== exp) begin
      errors++;
      $display("FAIL basic_setup: req=%b data=%h, want 0 %h", req_out, data_out, exp);
    end
    tick();
    checks++;
    if (req_out !== 1'b1) begin
      errors++;
      $display("FAIL basic_req_rise: req=%b, want 1", req_out);
    end
    for (int t = 1; t <= 20; t++) begin
      tick();
      checks++;
      if (data_out !== exp || timeout !== 1'b0) begin
        errors++;
        $display("FAIL basic_hold[%0d]: data=%h to=%b, want %h 0", t, data_out, timeout, exp);
      end
      if (done) begin
        n_done++;
        if (t_done < 0) t_done = t;
      end
    end
    checks++;
    if (n_done != 1 || t_done != 12) begin
      errors++;
      $display("FAIL basic_done: pulses=%0d at=%0d, want 1 at 12", n_done, t_done);
    end
    got = sb.pop_front();
    checks++;
    if (data_out !== got || send_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_end: data=%h ready=%b, want %h 1", data_out, send_ready, got);
    end
  endtask

  task automatic test_back_to_back();
    int n_done = 0, n_acc = 0;
    bit acc;
    logic prev_req = 1'b0;
    logic [7:0] prev_d = 8'h00, got;
    rx_en = 1'b1;
    send_valid = 1'b1;
    send_data = 8'h01;
    for (int t = 0; t < 80 && n_done < 2; t++) begin
      acc = send_valid && send_ready;
      if (acc) begin
        checks++;
        if (n_acc != n_done) begin
          errors++;
          $display("FAIL b2b_early_accept: accepts=%0d dones=%0d, want equal", n_acc, n_done);
        end
        sb.push_back(send_data);
        n_acc++;
      end
      tick();
      if (acc) begin
        if (send_data == 8'h01) send_data = 8'h02;
        else send_valid = 1'b0;
      end
      if (prev_req && req_out) begin
        checks++;
        if (data_out !== prev_d) begin
          errors++;
          $display("FAIL b2b_data_stable: data=%h, want %h", data_out, prev_d);
        end
      end
      if (done) begin
        n_done++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_spurious_done: done=1, want 0");
        end else begin
          got = sb.pop_front();
          if (data_out !== got) begin
            errors++;
            $display("FAIL b2b_done_data: data=%h, want %h", data_out, got);
          end
        end
      end
      prev_req = req_out;
      prev_d = data_out;
    end
    send_valid = 1'b0;
    checks++;
    if (n_done != 2 || n_acc != 2) begin
      errors++;
      $display("FAIL b2b_count: dones=%0d accepts=%0d, want 2 2", n_done, n_acc);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    rx_en = 1'b0;
    ack_async = 1'b0;
    send(8'hC3, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL to_accept: send_ready stayed %b, want 1", send_ready);
      return;
    end
    tick();
    for (int t = 1; t <= 16; t++) begin
      tick();
      checks++;
      if (t < 16 && (req_out !== 1'b1 || timeout !== 1'b0 || done !== 1'b0)) begin
        errors++;
        $display("FAIL to_wait[%0d]: req=%b to=%b done=%b, want 1 0 0", t, req_out, timeout, done);
      end
      if (t == 16 && (timeout !== 1'b1 || req_out !== 1'b0 || done !== 1'b0 || send_ready !== 1'b0 || data_out !== sb[0])) begin
        errors++;
        $display("FAIL to_pulse: to=%b req=%b done=%b ready=%b data=%h, want 1 0 0 0 %h",
                 timeout, req_out, done, send_ready, data_out, sb[0]);
      end
    end
    tick();
    checks++;
    if (send_ready !== 1'b1 || timeout !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL to_recover: ready=%b to=%b done=%b, want 1 0 0", send_ready, timeout, done);
    end
    void'(sb.pop_front());
  endtask

  task automatic test_late_ack();
    bit ok;
    send(8'h3C, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL late_accept: send_ready stayed %b, want 1", send_ready);
      return;
    end
    repeat (15) tick();
    ack_async = 1'b1;
    tick();
    checks++;
    if (req_out !== 1'b1 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL late_pre: req=%b to=%b, want 1 0", req_out, timeout);
    end
    tick();
    checks++;
    if (timeout !== 1'b1 || req_out !== 1'b0) begin
      errors++;
      $display("FAIL late_timeout: to=%b req=%b, want 1 0", timeout, req_out);
    end
    for (int t = 0; t < 5; t++) begin
      if (t == 3) ack_async = 1'b0;
      tick();
      checks++;
      if (send_ready !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL late_hold[%0d]: ready=%b done=%b to=%b, want 0 0 0", t, send_ready, done, timeout);
      end
    end
    tick();
    checks++;
    if (send_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL late_idle: ready=%b done=%b, want 1 0", send_ready, done);
    end
    void'(sb.pop_front());
  endtask

  task automatic test_reset_mid();
    bit ok;
    send(8'h77, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_accept: send_ready stayed %b, want 1", send_ready);
      return;
    end
    repeat (4) tick();
    Reset = 1'b0;
    tick();
    checks++;
    if (req_out !== 1'b0 || data_out !== 8'h00 || done !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: req=%b data=%h done=%b to=%b, want 0 00 0 0", req_out, data_out, done, timeout);
    end
    Reset = 1'b1;
    sb.delete();
    for (int t = 0; t < 20; t++) begin
      tick();
      checks++;
      if (req_out !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 || send_ready !== 1'b1) begin
        errors++;
        $display("FAIL mid_after[%0d]: req=%b done=%b to=%b ready=%b, want 0 0 0 1", t, req_out, done, timeout, send_ready);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_late_ack();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
